// File: rtl/elevator_cmd_port_if.sv
// Byte-stream link between the host (UART side) and the elevator command port.
// rx carries command bytes into the block, tx carries ASCII status bytes out.
interface elevator_cmd_port_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/elevator_cmd_port.sv
// ASCII command responder for smart_elevator: decodes S / R<d> / E<c> / X,
// drives req/emergency/elev_reset and streams ACK or STATE lines back to the host.
module elevator_cmd_port #(
  parameter int STEP_CYCLES = 10,
  parameter int RST_CYCLES  = 1,
  parameter int STATE_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  elevator_cmd_port_if.slave bus,
  output logic [7:0]         req,
  output logic               emergency,
  output logic               elev_reset,
  input  logic [STATE_W-1:0] st_state,
  input  logic [2:0]         st_floor,
  input  logic               st_dir,
  input  logic               st_motor,
  input  logic               st_door,
  input  logic               st_alarm
);
  localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  localparam logic [7:0] C_S = 8'h53;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_E = 8'h45;
  localparam logic [7:0] C_X = 8'h58;
  localparam logic [7:0] C_1 = 8'h31;

  // Templates; '?' / '0' positions are overwritten with argument or snapshot digits.
  localparam logic [79:0]  T_RST = "ACK:RESET\n";
  localparam logic [111:0] T_REQ = "ACK:REQUEST_?\n";
  localparam logic [127:0] T_EMG = "ACK:EMERGENCY_?\n";
  localparam logic [359:0] T_ST  = "STATE:0|FLOOR:0|DIR:0|MOTOR:0|DOOR:0|ALARM:0\n";

  typedef enum logic [1:0] {IDLE, ARG, WAIT, TX} state_e;
  typedef enum logic [1:0] {M_RST, M_REQ, M_EMG, M_ST} msg_e;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [2:0]         floor;
    logic               dir;
    logic               motor;
    logic               door;
    logic               alarm;
  } status_t;

  state_e           state_q, state_d;
  msg_e             msg_q;
  logic [7:0]       cmd_q, arg_q;
  logic [5:0]       idx_q, last_idx;
  logic [SCW-1:0]   step_q;
  logic [RCW-1:0]   rst_cnt_q;
  status_t          snap_q;
  logic [7:0]       tx_byte;
  logic             rx_fire, tx_fire, step_done, tx_last, is_digit;

  assign rx_fire   = (state_q == IDLE || state_q == ARG) && bus.rx_valid;
  assign tx_fire   = (state_q == TX) && bus.tx_ready;
  assign step_done = (step_q == SCW'(STEP_CYCLES - 1));
  assign tx_last   = (idx_q == last_idx);
  assign is_digit  = (bus.rx_data[7:3] == 5'b00110);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (rx_fire) begin
        if (bus.rx_data == C_S)                           state_d = WAIT;
        else if (bus.rx_data == C_R || bus.rx_data == C_E) state_d = ARG;
        else if (bus.rx_data == C_X)                      state_d = TX;
      end
      ARG: if (rx_fire) begin
        if (cmd_q == C_E || is_digit) state_d = TX;
        else                          state_d = IDLE;
      end
      WAIT: if (step_done) state_d = TX;
      TX:   if (tx_fire && tx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_ready = (state_q == IDLE) || (state_q == ARG);
    bus.tx_valid = (state_q == TX);
    bus.tx_data  = (state_q == TX) ? tx_byte : 8'h00;
    elev_reset   = (rst_cnt_q != '0);
  end

  // Byte generator: template byte at idx_q with the variable digits spliced in.
  always_comb begin
    tx_byte  = 8'h00;
    last_idx = 6'd0;
    unique case (msg_q)
      M_RST: begin
        last_idx = 6'd9;
        tx_byte  = T_RST[8*(9 - int'(idx_q)) +: 8];
      end
      M_REQ: begin
        last_idx = 6'd13;
        tx_byte  = (idx_q == 6'd12) ? arg_q : T_REQ[8*(13 - int'(idx_q)) +: 8];
      end
      M_EMG: begin
        last_idx = 6'd15;
        tx_byte  = (idx_q == 6'd14) ? arg_q : T_EMG[8*(15 - int'(idx_q)) +: 8];
      end
      M_ST: begin
        last_idx = 6'd44;
        tx_byte  = T_ST[8*(44 - int'(idx_q)) +: 8];
        case (idx_q)
          6'd6:  tx_byte = 8'h30 + 8'(snap_q.state);
          6'd14: tx_byte = 8'h30 + 8'(snap_q.floor);
          6'd20: tx_byte = 8'h30 + 8'(snap_q.dir);
          6'd28: tx_byte = 8'h30 + 8'(snap_q.motor);
          6'd35: tx_byte = 8'h30 + 8'(snap_q.door);
          6'd43: tx_byte = 8'h30 + 8'(snap_q.alarm);
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_q     <= M_RST;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      idx_q     <= 6'd0;
      step_q    <= '0;
      rst_cnt_q <= '0;
      snap_q    <= '0;
      req       <= 8'h00;
      emergency <= 1'b0;
    end else begin
      req <= 8'h00;
      if (rst_cnt_q != '0) rst_cnt_q <= rst_cnt_q - 1'b1;
      unique case (state_q)
        IDLE: if (rx_fire) begin
          cmd_q  <= bus.rx_data;
          step_q <= '0;
          idx_q  <= 6'd0;
          if (bus.rx_data == C_X) begin
            rst_cnt_q <= RCW'(RST_CYCLES);
            msg_q     <= M_RST;
          end
        end
        ARG: if (rx_fire) begin
          arg_q <= bus.rx_data;
          idx_q <= 6'd0;
          if (cmd_q == C_E) begin
            emergency <= (bus.rx_data == C_1);
            msg_q     <= M_EMG;
          end else if (is_digit) begin
            req   <= 8'd1 << bus.rx_data[2:0];
            msg_q <= M_REQ;
          end
        end
        WAIT: begin
          step_q <= step_q + 1'b1;
          if (step_done) begin
            snap_q <= '{state: st_state, floor: st_floor, dir: st_dir,
                        motor: st_motor, door: st_door, alarm: st_alarm};
            msg_q  <= M_ST;
            idx_q  <= 6'd0;
          end
        end
        TX: if (tx_fire) idx_q <= idx_q + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_cmd_port.sv
// Scoreboard bench: a protocol-level model queues expected tx bytes, req pulses
// and reset pulses; an independent monitor compares whatever the DUT emits.
module tb_elevator_cmd_port;
  localparam int RST_CYCLES = 1;
  localparam byte unsigned C_S = 8'h53, C_R = 8'h52, C_E = 8'h45, C_X = 8'h58;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] req;
  logic       emergency, elev_reset;
  logic [2:0] st_state, st_floor;
  logic       st_dir, st_motor, st_door, st_alarm;

  elevator_cmd_port_if bus();

  elevator_cmd_port dut (
    .clk(clk), .reset(reset), .bus(bus),
    .req(req), .emergency(emergency), .elev_reset(elev_reset),
    .st_state(st_state), .st_floor(st_floor), .st_dir(st_dir),
    .st_motor(st_motor), .st_door(st_door), .st_alarm(st_alarm)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  byte unsigned exp_q[$];
  logic [7:0]   req_q[$];
  int exp_pulses = 0, seen_pulses = 0;
  logic         m_emg = 1'b0;
  byte unsigned m_pend = 8'h00;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_str(string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Protocol model: what each accepted byte should produce.
  task automatic model(byte unsigned b);
    if (m_pend == 8'h00) begin
      if (b == C_S)
        push_str($sformatf("STATE:%0d|FLOOR:%0d|DIR:%0d|MOTOR:%0d|DOOR:%0d|ALARM:%0d\n",
                           st_state, st_floor, st_dir, st_motor, st_door, st_alarm));
      else if (b == C_R || b == C_E) m_pend = b;
      else if (b == C_X) begin
        push_str("ACK:RESET\n");
        exp_pulses++;
      end
    end else begin
      if (m_pend == C_R) begin
        if (b >= 8'h30 && b <= 8'h37) begin
          req_q.push_back(8'd1 << (b - 8'h30));
          push_str($sformatf("ACK:REQUEST_%c\n", b));
        end
      end else begin
        m_emg = (b == 8'h31);
        push_str($sformatf("ACK:EMERGENCY_%c\n", b));
      end
      m_pend = 8'h00;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(byte unsigned b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 2000) begin step(); n++; end
    if (n >= 2000) begin
      chk("rx_accept_timeout", 1, 0);
      bus.rx_valid = 1'b0;
      return;
    end
    step();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model(b);
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!bus.tx_valid && n < 100) begin step(); n++; end
    if (n >= 100) chk("tx_start_timeout", 1, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.tx_valid) && n < 5000) begin step(); n++; end
    if (n >= 5000) chk("drain_timeout", 1, 0);
    step();
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: stream compare, hold-stability, rx blocking, pulse tracking.
  bit         hold_pend = 0;
  logic [7:0] held_data;
  int         rst_run = 0;
  always @(negedge clk) begin
    if (!reset) begin
      hold_pend = 0;
      rst_run   = 0;
    end else begin
      if (hold_pend) begin
        chk("tx_valid_held", bus.tx_valid, 1);
        chk("tx_data_held", bus.tx_data, held_data);
      end
      hold_pend = bus.tx_valid && !bus.tx_ready;
      held_data = bus.tx_data;
      if (bus.tx_valid) chk("rx_ready_during_tx", bus.rx_ready, 0);
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected", bus.tx_data, 8'hxx);
        else chk("tx_byte", bus.tx_data, exp_q.pop_front());
      end
      if (req != 8'h00) begin
        if (req_q.size() == 0) chk("req_unexpected", req, 8'h00);
        else chk("req_pulse", req, req_q.pop_front());
      end
      if (elev_reset) rst_run++;
      else if (rst_run != 0) begin
        chk("elev_reset_len", rst_run, RST_CYCLES);
        seen_pulses++;
        rst_run = 0;
      end
    end
  end

  initial begin
    byte unsigned b;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    {st_state, st_floor, st_dir, st_motor, st_door, st_alarm} = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_req", req, 0);
    chk("rst_emergency", emergency, 0);
    chk("rst_elev_reset", elev_reset, 0);
    reset = 1'b1;
    step();
    chk("rst_rx_ready", bus.rx_ready, 1);

    send(C_R); send("3"); drain();
    send(C_R); send("9"); send(C_E); send("1");
    chk("emergency_set", emergency, 1);
    drain();

    {st_state, st_floor, st_dir, st_motor, st_door, st_alarm} = {3'd2, 3'd5, 4'b1100};
    send(C_S); wait_tx();
    st_floor = 3'd6;
    drain();

    send(C_X); drain();
    chk("emergency_after_x", emergency, 1);
    send("Q"); send(8'h0A); drain();

    // Reset in the middle of a STATE line.
    send(C_S); wait_tx();
    for (int n = 0; n < 500 && exp_q.size() > 30; n++) step();
    reset = 1'b0;
    #1;
    chk("midrst_tx_valid", bus.tx_valid, 0);
    chk("midrst_emergency", emergency, 0);
    chk("midrst_req", req, 0);
    exp_q.delete(); req_q.delete();
    m_emg = 1'b0; m_pend = 8'h00;
    step(); step();
    reset = 1'b1;
    step();
    send(C_R); send("0"); drain();

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: begin
          {st_state, st_floor, st_dir, st_motor, st_door, st_alarm} = 10'($urandom);
          send(C_S); wait_tx();
          {st_state, st_floor, st_dir, st_motor, st_door, st_alarm} = 10'($urandom);
        end
        1: begin send(C_R); send(8'($urandom_range(8'h30, 8'h39))); end
        2: begin
          b = ($urandom_range(0, 1) != 0) ? 8'h31 : 8'($urandom_range(8'h30, 8'h41));
          send(C_E); send(b);
          chk("emergency_level", emergency, m_emg);
        end
        3: send(C_X);
        default: send(8'($urandom_range(8'h0A, 8'h51)) == C_E ? 8'h0D : 8'h51);
      endcase
      if ($urandom_range(0, 1) != 0) drain();
    end
    drain();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("req_q_empty", req_q.size(), 0);
    chk("reset_pulse_count", seen_pulses, exp_pulses);
    chk("emergency_final", emergency, m_emg);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
